stream_run_sequencer: RTL and testbench

Command-level sequencer that drives the network source stream. It accepts host commands to queue input charges, run the network for N timesteps, or clear it. It expands each command into the packed source packets (opcode + per-input charges) consumed by the network source. It sits between the host/command decoder and the source handshake of the network, and owns timestep pacing and charge staging.

---
 rtl/stream_run_sequencer_if.sv | 45 ++++
 rtl/stream_run_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stream_run_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_run_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stream_run_sequencer_if
//  Purpose  : Command and source-packet handshake bundle of the run sequencer.
//             'master' is the sequencer side (drives cmd_ready and the source
//             stream); 'slave' is the host/network side.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_run_sequencer_if #(
  parameter int NUM_INP      = 4,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 16,
  parameter int IDX_WIDTH    = (NUM_INP > 1) ? $clog2(NUM_INP) : 1
);
  localparam int PKT_WIDTH = 1 + NUM_INP * CHARGE_WIDTH;

  // Command channel
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [IDX_WIDTH-1:0]    cmd_idx;
  logic [CHARGE_WIDTH-1:0] cmd_charge;
  logic [RUN_WIDTH-1:0]    cmd_run;

  // Source packet channel
  logic                    src_valid;
  logic                    src_ready;
  logic [PKT_WIDTH-1:0]    src;

  // Status
  logic                    busy;
  logic [RUN_WIDTH-1:0]    steps_done;

  modport master (
    input  cmd_valid, cmd_op, cmd_idx, cmd_charge, cmd_run, src_ready,
    output cmd_ready, src_valid, src, busy, steps_done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_idx, cmd_charge, cmd_run, src_ready,
    input  cmd_ready, src_valid, src, busy, steps_done
  );
endinterface
`default_nettype wire

// File: rtl/stream_run_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stream_run_sequencer
//  Purpose  : Expands host commands (NOP / SPK / RUN / CLR) into packed source
//             packets for the network: stages per-input charges with
//             saturation, paces RUN timesteps and counts accepted steps.
//  Revision : 1.0  initial release
// ============================================================================
module stream_run_sequencer #(
  parameter int NUM_INP      = 4,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 16,
  parameter int IDX_WIDTH    = (NUM_INP > 1) ? $clog2(NUM_INP) : 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  stream_run_sequencer_if.master bus
);

  localparam int PAY_WIDTH = NUM_INP * CHARGE_WIDTH;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SPK = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  localparam logic PKT_NOM = 1'b0;
  localparam logic PKT_CLR = 1'b1;

  localparam logic [CHARGE_WIDTH-1:0] CHG_MAX = {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
  localparam logic [CHARGE_WIDTH-1:0] CHG_MIN = {1'b1, {(CHARGE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t                         state_q;
  logic                           src_valid_q;
  logic [PAY_WIDTH:0]             src_q;
  logic [RUN_WIDTH-1:0]           remaining_q;
  logic [RUN_WIDTH-1:0]           steps_q;
  logic signed [CHARGE_WIDTH-1:0] pending_q [NUM_INP];

  // Saturated "pending + cmd_charge" for every lane, and which lane SPK hits.
  logic [PAY_WIDTH-1:0]           pending_sat_d;
  logic [NUM_INP-1:0]             idx_hit;
  // Pending charges laid out in packet order (input 0 just below the opcode).
  logic [PAY_WIDTH-1:0]           pending_packed;

  for (genvar i = 0; i < NUM_INP; i++) begin : g_lane
    logic [CHARGE_WIDTH:0] sum;
    logic                  ovf;

    // One guard bit: overflow when the two top bits of the sum disagree.
    assign sum = {pending_q[i][CHARGE_WIDTH-1], pending_q[i]}
               + {bus.cmd_charge[CHARGE_WIDTH-1], bus.cmd_charge};
    assign ovf = sum[CHARGE_WIDTH] ^ sum[CHARGE_WIDTH-1];

    assign pending_sat_d[i*CHARGE_WIDTH +: CHARGE_WIDTH] =
      ovf ? (sum[CHARGE_WIDTH] ? CHG_MIN : CHG_MAX) : sum[CHARGE_WIDTH-1:0];

    // Indices >= NUM_INP match no lane, so such SPKs are silently dropped.
    assign idx_hit[i] = (bus.cmd_idx == IDX_WIDTH'(i));

    assign pending_packed[(NUM_INP-1-i)*CHARGE_WIDTH +: CHARGE_WIDTH] = pending_q[i];
  end

  // Command decode, packet generation, step pacing and charge staging.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      src_valid_q <= 1'b0;
      src_q       <= '0;
      remaining_q <= '0;
      steps_q     <= '0;
      for (int i = 0; i < NUM_INP; i++) begin
        pending_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_SPK: begin
                for (int i = 0; i < NUM_INP; i++) begin
                  if (idx_hit[i]) begin
                    pending_q[i] <= pending_sat_d[i*CHARGE_WIDTH +: CHARGE_WIDTH];
                  end
                end
              end
              OP_RUN: begin
                // A zero-length run is consumed without producing packets.
                if (bus.cmd_run != '0) begin
                  remaining_q <= bus.cmd_run;
                  state_q     <= ST_RUN;
                  src_valid_q <= 1'b1;
                  src_q       <= {PKT_NOM, pending_packed};
                end
              end
              OP_CLR: begin
                state_q     <= ST_CLR;
                src_valid_q <= 1'b1;
                src_q       <= {PKT_CLR, {PAY_WIDTH{1'b0}}};
              end
              default: begin
                // OP_NOP: accepted, nothing to do.
              end
            endcase
          end
        end

        ST_RUN: begin
          if (bus.src_ready) begin
            steps_q     <= steps_q + RUN_WIDTH'(1);
            remaining_q <= remaining_q - RUN_WIDTH'(1);
            // Staged charges are consumed by the first accepted packet.
            for (int i = 0; i < NUM_INP; i++) begin
              pending_q[i] <= '0;
            end
            if (remaining_q == RUN_WIDTH'(1)) begin
              state_q     <= ST_IDLE;
              src_valid_q <= 1'b0;
              src_q       <= '0;
            end else begin
              // Pending was just cleared and SPK cannot arrive while busy,
              // so every later packet of the run carries zero charges.
              src_q <= {PKT_NOM, {PAY_WIDTH{1'b0}}};
            end
          end
        end

        ST_CLR: begin
          if (bus.src_ready) begin
            for (int i = 0; i < NUM_INP; i++) begin
              pending_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            src_valid_q <= 1'b0;
            src_q       <= '0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          src_valid_q <= 1'b0;
          src_q       <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.src_valid  = src_valid_q;
  assign bus.src        = src_q;
  assign bus.steps_done = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_run_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stream_run_sequencer
//  Purpose  : Directed self-checking bench for stream_run_sequencer. A 4-input
//             instance carries the main checks; a 3-input instance sees the
//             same command stream to exercise an out-of-range SPK index.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_run_sequencer;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SPK = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  logic        clk        = 1'b0;
  logic        arstn      = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic [1:0]  cmd_op     = 2'd0;
  logic [1:0]  cmd_idx    = 2'd0;
  logic [7:0]  cmd_charge = 8'd0;
  logic [15:0] cmd_run    = 16'd0;
  logic        src_ready  = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_steps;
  int hs;

  always #5 clk = ~clk;

  stream_run_sequencer_if #(.NUM_INP(4), .CHARGE_WIDTH(8), .RUN_WIDTH(16), .IDX_WIDTH(2)) if4 ();
  stream_run_sequencer_if #(.NUM_INP(3), .CHARGE_WIDTH(8), .RUN_WIDTH(16), .IDX_WIDTH(2)) if3 ();

  assign if4.cmd_valid  = cmd_valid;
  assign if4.cmd_op     = cmd_op;
  assign if4.cmd_idx    = cmd_idx;
  assign if4.cmd_charge = cmd_charge;
  assign if4.cmd_run    = cmd_run;
  assign if4.src_ready  = src_ready;
  assign if3.cmd_valid  = cmd_valid;
  assign if3.cmd_op     = cmd_op;
  assign if3.cmd_idx    = cmd_idx;
  assign if3.cmd_charge = cmd_charge;
  assign if3.cmd_run    = cmd_run;
  assign if3.src_ready  = src_ready;

  stream_run_sequencer #(.NUM_INP(4), .CHARGE_WIDTH(8), .RUN_WIDTH(16), .IDX_WIDTH(2)) u_dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (if4)
  );

  stream_run_sequencer #(.NUM_INP(3), .CHARGE_WIDTH(8), .RUN_WIDTH(16), .IDX_WIDTH(2)) u_dut3 (
    .clk   (clk),
    .arstn (arstn),
    .bus   (if3)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] pkt4(input logic op, input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
    return {op, c0, c1, c2, c3};
  endfunction

  // Present one command at a negedge, accept it on the next posedge, and
  // return at the following negedge (cycle k+1 of the accepting edge k).
  task automatic send(input logic [1:0] op, input logic [1:0] idx, input logic [7:0] chg,
                      input logic [15:0] run);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_idx    = idx;
    cmd_charge = chg;
    cmd_run    = run;
    check_val("cmd_ready_at_send", 64'(if4.cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  initial begin
    logic [32:0] exp_src [5];
    logic        pat     [5];

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_val("rst_cmd_ready", 64'(if4.cmd_ready), 64'd1);
    check_val("rst_src_valid", 64'(if4.src_valid), 64'd0);
    check_val("rst_src",       64'(if4.src),       64'd0);
    check_val("rst_busy",      64'(if4.busy),      64'd0);
    check_val("rst_steps",     64'(if4.steps_done), 64'd0);
    arstn     = 1'b1;
    exp_steps = 0;

    // ---------------- basic run ----------------
    send(OP_SPK, 2'd0, 8'd5, 16'd0);
    send(OP_SPK, 2'd2, 8'hFD, 16'd0);
    send(OP_RUN, 2'd0, 8'd0, 16'd3);
    check_val("run3_valid_k1", 64'(if4.src_valid), 64'd1);
    check_val("run3_busy_k1",  64'(if4.busy),      64'd1);
    check_val("run3_rdy_k1",   64'(if4.cmd_ready), 64'd0);
    check_val("run3_pkt_k1",   64'(if4.src), 64'(pkt4(1'b0, 8'd5, 8'd0, 8'hFD, 8'd0)));
    @(negedge clk);
    check_val("run3_valid_k2", 64'(if4.src_valid), 64'd1);
    check_val("run3_pkt_k2",   64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    check_val("run3_valid_k3", 64'(if4.src_valid), 64'd1);
    check_val("run3_pkt_k3",   64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    exp_steps = 3;
    check_val("run3_valid_k4", 64'(if4.src_valid), 64'd0);
    check_val("run3_rdy_k4",   64'(if4.cmd_ready), 64'd1);
    check_val("run3_steps",    64'(if4.steps_done), 64'(exp_steps));

    // ---------------- saturation ----------------
    send(OP_SPK, 2'd1, 8'd100, 16'd0);
    send(OP_SPK, 2'd1, 8'd100, 16'd0);
    send(OP_SPK, 2'd3, 8'h9C, 16'd0);
    send(OP_SPK, 2'd3, 8'h9C, 16'd0);
    send(OP_RUN, 2'd0, 8'd0, 16'd1);
    check_val("sat_pkt", 64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'h7F, 8'd0, 8'h80)));
    @(negedge clk);
    exp_steps = 4;
    check_val("sat_idle",  64'(if4.busy),       64'd0);
    check_val("sat_steps", 64'(if4.steps_done), 64'(exp_steps));

    // ---------------- backpressure ----------------
    send(OP_SPK, 2'd0, 8'd9, 16'd0);
    src_ready = 1'b0;
    send(OP_RUN, 2'd0, 8'd0, 16'd2);
    pat     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_src = '{pkt4(1'b0, 8'd9, 8'd0, 8'd0, 8'd0), pkt4(1'b0, 8'd9, 8'd0, 8'd0, 8'd0),
                pkt4(1'b0, 8'd9, 8'd0, 8'd0, 8'd0), 33'd0, 33'd0};
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      src_ready = pat[c];
      check_val($sformatf("bp_valid_c%0d", c), 64'(if4.src_valid), 64'd1);
      check_val($sformatf("bp_src_c%0d", c),   64'(if4.src),       64'(exp_src[c]));
      if (if4.src_valid && src_ready) hs++;
      @(negedge clk);
    end
    src_ready = 1'b1;
    exp_steps = 6;
    check_val("bp_handshakes", 64'(hs),              64'd2);
    check_val("bp_busy_after", 64'(if4.busy),        64'd0);
    check_val("bp_valid_after", 64'(if4.src_valid),  64'd0);
    check_val("bp_steps",      64'(if4.steps_done),  64'(exp_steps));

    // ---------------- clear ----------------
    send(OP_SPK, 2'd0, 8'd7, 16'd0);
    send(OP_CLR, 2'd0, 8'd0, 16'd0);
    check_val("clr_valid", 64'(if4.src_valid), 64'd1);
    check_val("clr_pkt",   64'(if4.src), 64'(pkt4(1'b1, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    check_val("clr_done_valid", 64'(if4.src_valid),  64'd0);
    check_val("clr_steps",      64'(if4.steps_done), 64'(exp_steps));
    send(OP_RUN, 2'd0, 8'd0, 16'd1);
    check_val("post_clr_pkt", 64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    exp_steps = 7;
    check_val("post_clr_steps", 64'(if4.steps_done), 64'(exp_steps));

    // ---------------- RUN 0 ----------------
    send(OP_RUN, 2'd0, 8'd0, 16'd0);
    check_val("run0_valid", 64'(if4.src_valid), 64'd0);
    check_val("run0_rdy",   64'(if4.cmd_ready), 64'd1);
    @(negedge clk);
    check_val("run0_valid2", 64'(if4.src_valid), 64'd0);
    check_val("run0_steps",  64'(if4.steps_done), 64'(exp_steps));

    // ---------------- out-of-range index (3-input instance) ----------------
    send(OP_SPK, 2'd3, 8'd50, 16'd0);
    send(OP_SPK, 2'd2, 8'd1, 16'd0);
    send(OP_RUN, 2'd0, 8'd0, 16'd1);
    check_val("idx_pkt4", 64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd1, 8'd50)));
    check_val("idx_pkt3", 64'(if3.src), 64'h000001);
    check_val("idx_valid3", 64'(if3.src_valid), 64'd1);
    @(negedge clk);
    exp_steps = 8;

    // ---------------- reset while idle clears pending ----------------
    send(OP_SPK, 2'd0, 8'd3, 16'd0);
    #2 arstn = 1'b0;
    #2 check_val("idle_rst_steps", 64'(if4.steps_done), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    send(OP_RUN, 2'd0, 8'd0, 16'd1);
    check_val("idle_rst_pkt", 64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    exp_steps = 1;

    // ---------------- reset mid-run ----------------
    send(OP_RUN, 2'd0, 8'd0, 16'd10);
    repeat (4) @(negedge clk);
    exp_steps = 5;
    check_val("mid_steps_before", 64'(if4.steps_done), 64'(exp_steps));
    check_val("mid_busy_before",  64'(if4.busy),       64'd1);
    #1 arstn = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(if4.src_valid),  64'd0);
    check_val("mid_rst_steps", 64'(if4.steps_done), 64'd0);
    check_val("mid_rst_busy",  64'(if4.busy),       64'd0);
    check_val("mid_rst_rdy",   64'(if4.cmd_ready),  64'd1);
    @(negedge clk);
    arstn = 1'b1;
    send(OP_RUN, 2'd0, 8'd0, 16'd2);
    check_val("clean_pkt1", 64'(if4.src), 64'(pkt4(1'b0, 8'd0, 8'd0, 8'd0, 8'd0)));
    @(negedge clk);
    check_val("clean_valid2", 64'(if4.src_valid), 64'd1);
    @(negedge clk);
    exp_steps = 2;
    check_val("clean_valid_end", 64'(if4.src_valid),  64'd0);
    check_val("clean_steps",     64'(if4.steps_done), 64'(exp_steps));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
